// File: rtl/pep_ks_common_param_pkg.sv
// pep_ks_common_param_pkg: key-switch geometry shared by the BLRAM read scheduler
// and the chain pipes that follow it.
package pep_ks_common_param_pkg;
    localparam int BLWE_K = 10;
    localparam int LBY = 4;
    localparam int Y_NB = (BLWE_K + LBY - 1) / LBY;
    localparam int BLWE_RAM_DEPTH_DEF = Y_NB * 8 * 4;
    localparam int SLOT_NB = BLWE_RAM_DEPTH_DEF / Y_NB;
    localparam int SLOT_W = $clog2(SLOT_NB);

    typedef struct packed {
        logic [SLOT_W-1:0] slot;
        logic              side;
    } ks_rd_cmd_t;
endpackage

// File: rtl/pep_ks_ctrl_read_dly.sv
// pep_ks_ctrl_read_dly: fixed-depth valid+payload shift register; only valids are reset,
// so payload bits cost no reset routing.
module pep_ks_ctrl_read_dly #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             s_rst_n,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0][WIDTH-1:0] data;

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            vld <= '0;
        end else begin
            vld[0] <= in_vld;
            for (int i = 1; i < DEPTH; i++) vld[i] <= vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        data[0] <= in_data;
        for (int i = 1; i < DEPTH; i++) data[i] <= data[i-1];
    end

    assign out_vld  = vld[DEPTH-1];
    assign out_data = data[DEPTH-1];
    assign busy     = |vld;
endmodule

// File: rtl/pep_ks_ctrl_read_sched.sv
// pep_ks_ctrl_read_sched: issues one spaced, credit-throttled BLRAM read per y-line of a
// BLWE slot and emits the matching data-valid stream aligned to the read latency.
module pep_ks_ctrl_read_sched
    import pep_ks_common_param_pkg::*;
#(
    parameter int BLWE_RAM_DEPTH = Y_NB * 8 * 4,
    parameter int RAM_LATENCY    = 2,
    parameter int SIDE_W         = 1,
    parameter int CREDIT_NB      = 4,
    parameter int KS_LG_NB       = 3,
    localparam int RD_SLOT_W      = $clog2(BLWE_RAM_DEPTH / Y_NB),
    localparam int BLWE_RAM_ADD_W = $clog2(BLWE_RAM_DEPTH)
) (
    input  logic                      clk,
    input  logic                      s_rst_n,
    input  logic                      cmd_vld,
    output logic                      cmd_rdy,
    input  logic [RD_SLOT_W-1:0]      cmd_slot,
    input  logic [SIDE_W-1:0]         cmd_side,
    output logic                      seq_avail,
    output logic [BLWE_RAM_ADD_W-1:0] seq_add,
    output logic                      seq_data_avail,
    output logic                      seq_data_last_y,
    output logic [SIDE_W-1:0]         seq_data_side,
    input  logic                      credit_inc,
    output logic                      cmd_done,
    output logic                      busy
);
    localparam int Y_W   = Y_NB > 1 ? $clog2(Y_NB) : 1;
    localparam int SPC_W = KS_LG_NB > 1 ? $clog2(KS_LG_NB) : 1;
    localparam int CR_W  = $clog2(CREDIT_NB + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state, state_n;
    logic [RD_SLOT_W-1:0] slot;
    logic [SIDE_W-1:0]   side;
    logic [Y_W-1:0]      y;
    logic [SPC_W-1:0]    spc;
    logic [CR_W-1:0]     credit;
    logic [SIDE_W:0]     dly_out;
    logic                hs, issue, last_y, over, dly_busy;

    assign cmd_rdy   = state == IDLE;
    assign hs        = cmd_rdy && cmd_vld;
    assign issue     = state == RUN && spc == '0 && credit != '0;
    assign last_y    = y == Y_W'(Y_NB - 1);
    assign over      = credit_inc && !issue && credit == CR_W'(CREDIT_NB);
    assign seq_avail = issue;
    assign seq_add   = BLWE_RAM_ADD_W'(32'(slot) * 32'(Y_NB) + 32'(y));

    always_comb begin
        state_n = state;
        if (hs) state_n = RUN;
        else if (issue && last_y) state_n = IDLE;
    end

    // spacing keeps counting down across command boundaries
    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state  <= IDLE;
            spc    <= '0;
            credit <= CR_W'(CREDIT_NB);
        end else begin
            state  <= state_n;
            spc    <= issue ? SPC_W'(KS_LG_NB - 1) : spc - SPC_W'(spc != '0);
            credit <= credit + CR_W'(credit_inc && !over) - CR_W'(issue);
            assert (!over) else $fatal(1, "credit_inc returned with credit already full");
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            slot <= cmd_slot;
            side <= cmd_side;
        end
        y <= hs ? '0 : y + Y_W'(issue);
    end

    pep_ks_ctrl_read_dly #(
        .DEPTH(RAM_LATENCY + 1),
        .WIDTH(SIDE_W + 1)
    ) u_dly (
        .clk      (clk),
        .s_rst_n  (s_rst_n),
        .in_vld   (issue),
        .in_data  ({last_y, side}),
        .out_vld  (seq_data_avail),
        .out_data (dly_out),
        .busy     (dly_busy)
    );

    assign seq_data_last_y = dly_out[SIDE_W];
    assign seq_data_side   = dly_out[SIDE_W-1:0];
    assign cmd_done        = seq_data_avail && seq_data_last_y;
    assign busy            = state != IDLE || dly_busy;
endmodule

// File: tb/tb_pep_ks_ctrl_read_sched.sv
// tb_pep_ks_ctrl_read_sched: directed checks of issue spacing, addressing, data alignment,
// credit throttling and reset, on a KS_LG_NB=3 instance and a KS_LG_NB=1 instance.
module tb_pep_ks_ctrl_read_sched;
    logic       clk = 0, s_rst_n = 0;
    logic       cmd_vld = 0, cmd_side = 0, credit_inc = 0;
    logic [2:0] cmd_slot = '0;
    logic       cmd_rdy, seq_avail, seq_data_avail, seq_data_last_y, seq_data_side, cmd_done, busy;
    logic [4:0] seq_add;
    logic       cmd_vld_b = 0, cmd_side_b = 0, credit_inc_b = 0;
    logic [2:0] cmd_slot_b = '0;
    logic       cmd_rdy_b, seq_avail_b, seq_data_avail_b, seq_data_last_y_b, seq_data_side_b, cmd_done_b, busy_b;
    logic [4:0] seq_add_b;
    int         checks = 0, errors = 0;
    int         iss_cyc[8], iss_add[8], n_iss;
    logic       iss_side[8], iss_last[8];

    always #5 clk = ~clk;

    pep_ks_ctrl_read_sched #(.BLWE_RAM_DEPTH(24), .RAM_LATENCY(2), .SIDE_W(1), .CREDIT_NB(4), .KS_LG_NB(3)) u0 (
        .clk(clk), .s_rst_n(s_rst_n), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_slot(cmd_slot),
        .cmd_side(cmd_side), .seq_avail(seq_avail), .seq_add(seq_add), .seq_data_avail(seq_data_avail),
        .seq_data_last_y(seq_data_last_y), .seq_data_side(seq_data_side), .credit_inc(credit_inc),
        .cmd_done(cmd_done), .busy(busy));

    pep_ks_ctrl_read_sched #(.BLWE_RAM_DEPTH(24), .RAM_LATENCY(2), .SIDE_W(1), .CREDIT_NB(4), .KS_LG_NB(1)) u1 (
        .clk(clk), .s_rst_n(s_rst_n), .cmd_vld(cmd_vld_b), .cmd_rdy(cmd_rdy_b), .cmd_slot(cmd_slot_b),
        .cmd_side(cmd_side_b), .seq_avail(seq_avail_b), .seq_add(seq_add_b), .seq_data_avail(seq_data_avail_b),
        .seq_data_last_y(seq_data_last_y_b), .seq_data_side(seq_data_side_b), .credit_inc(credit_inc_b),
        .cmd_done(cmd_done_b), .busy(busy_b));

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic set_iss(input int i, input int cyc, input int add, input logic sd, input logic lst);
        iss_cyc[i] = cyc; iss_add[i] = add; iss_side[i] = sd; iss_last[i] = lst;
    endtask

    // data beats follow each issue by RAM_LATENCY+1 = 3 cycles
    task automatic check_cycle(input bit b, input int k);
        logic e_av, e_dav, e_last, e_side;
        int   e_add;
        e_av = 0; e_dav = 0; e_last = 0; e_side = 0; e_add = 0;
        for (int i = 0; i < n_iss; i++) begin
            if (iss_cyc[i] == k) begin e_av = 1; e_add = iss_add[i]; end
            if (iss_cyc[i] + 3 == k) begin e_dav = 1; e_last = iss_last[i]; e_side = iss_side[i]; end
        end
        chk("seq_avail", k, b ? seq_avail_b : seq_avail, e_av);
        if (e_av) chk("seq_add", k, b ? seq_add_b : seq_add, e_add);
        chk("seq_data_avail", k, b ? seq_data_avail_b : seq_data_avail, e_dav);
        if (e_dav) begin
            chk("seq_data_last_y", k, b ? seq_data_last_y_b : seq_data_last_y, e_last);
            chk("seq_data_side", k, b ? seq_data_side_b : seq_data_side, e_side);
        end
        chk("cmd_done", k, b ? cmd_done_b : cmd_done, e_dav && e_last);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_rdy", 0, cmd_rdy, 1);
        chk("rst_seq_avail", 0, seq_avail, 0);
        chk("rst_data_avail", 0, seq_data_avail, 0);
        chk("rst_cmd_done", 0, cmd_done, 0);
        chk("rst_busy", 0, busy, 0);
        chk("rst_credit", 0, u0.credit, 4);
        chk("rst_cmd_rdy_b", 0, cmd_rdy_b, 1);
        chk("rst_busy_b", 0, busy_b, 0);
        s_rst_n = 1;
        @(posedge clk); #1;

        // single command, slot 2 side 1; credits returned on issue cycles
        n_iss = 3;
        set_iss(0, 1, 6, 1, 0); set_iss(1, 4, 7, 1, 0); set_iss(2, 7, 8, 1, 1);
        for (int k = 0; k <= 11; k++) begin
            cmd_vld = k == 0; cmd_slot = 2; cmd_side = 1; credit_inc = k inside {1, 4, 7};
            #1;
            check_cycle(0, k);
            chk("s1_cmd_rdy", k, cmd_rdy, k == 0 || k >= 8);
            chk("s1_busy", k, busy, k >= 1 && k <= 10);
            @(posedge clk); #1;
        end
        chk("s1_credit", 12, u0.credit, 4);

        // back-to-back slot 0 then slot 7, spacing held across the boundary
        n_iss = 6;
        set_iss(0, 1, 0, 0, 0); set_iss(1, 4, 1, 0, 0); set_iss(2, 7, 2, 0, 1);
        set_iss(3, 10, 21, 1, 0); set_iss(4, 13, 22, 1, 0); set_iss(5, 16, 23, 1, 1);
        for (int k = 0; k <= 20; k++) begin
            cmd_vld = k <= 8; cmd_slot = k == 0 ? 3'd0 : 3'd7; cmd_side = k != 0;
            credit_inc = k inside {1, 4, 7, 10, 13, 16};
            #1;
            check_cycle(0, k);
            chk("s2_cmd_rdy", k, cmd_rdy, k == 0 || k == 8 || k >= 17);
            chk("s2_busy", k, busy, k >= 1 && k <= 19);
            @(posedge clk); #1;
        end

        // credit exhaustion: coincident return at credit 2, stall after 5 reads, resume on return
        set_iss(0, 1, 3, 0, 0); set_iss(1, 4, 4, 0, 0); set_iss(2, 7, 5, 0, 1);
        set_iss(3, 10, 9, 1, 0); set_iss(4, 13, 10, 1, 0); set_iss(5, 21, 11, 1, 1);
        for (int k = 0; k <= 25; k++) begin
            cmd_vld = k <= 8; cmd_slot = k == 0 ? 3'd1 : 3'd3; cmd_side = k != 0;
            credit_inc = k == 7 || k == 20;
            #1;
            check_cycle(0, k);
            chk("s3_cmd_rdy", k, cmd_rdy, k == 0 || k == 8 || k >= 22);
            chk("s3_busy", k, busy, k >= 1 && k <= 24);
            if (k == 8) chk("s3_credit_coincident", k, u0.credit, 2);
            if (k == 14 || k == 22) chk("s3_credit_empty", k, u0.credit, 0);
            if (k == 21) chk("s3_credit_one", k, u0.credit, 1);
            @(posedge clk); #1;
        end
        credit_inc = 1;
        repeat (4) begin @(posedge clk); #1; end
        credit_inc = 0;
        chk("s3_credit_refill", 0, u0.credit, 4);

        // reset after the 2nd read of a command drops the in-flight beat
        n_iss = 2;
        set_iss(0, 1, 15, 1, 0); set_iss(1, 4, 16, 1, 0);
        for (int k = 0; k <= 5; k++) begin
            cmd_vld = k == 0; cmd_slot = 5; cmd_side = 1;
            #1;
            check_cycle(0, k);
            @(posedge clk); #1;
        end
        chk("s4_busy_pre", 6, busy, 1);
        s_rst_n = 0;
        #1;
        chk("s4_seq_avail", 6, seq_avail, 0);
        chk("s4_data_avail", 6, seq_data_avail, 0);
        chk("s4_cmd_done", 6, cmd_done, 0);
        chk("s4_busy", 6, busy, 0);
        chk("s4_cmd_rdy", 6, cmd_rdy, 1);
        chk("s4_credit", 6, u0.credit, 4);
        repeat (2) @(posedge clk);
        #1 s_rst_n = 1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #2;
            chk("s4_post_data_avail", k, seq_data_avail, 0);
            chk("s4_post_seq_avail", k, seq_avail, 0);
            chk("s4_post_cmd_rdy", k, cmd_rdy, 1);
            chk("s4_post_busy", k, busy, 0);
        end
        @(posedge clk); #1;

        // KS_LG_NB=1 instance: back-to-back reads
        n_iss = 3;
        set_iss(0, 1, 12, 0, 0); set_iss(1, 2, 13, 0, 0); set_iss(2, 3, 14, 0, 1);
        for (int k = 0; k <= 7; k++) begin
            cmd_vld_b = k == 0; cmd_slot_b = 4; cmd_side_b = 0;
            #1;
            check_cycle(1, k);
            chk("s5_cmd_rdy", k, cmd_rdy_b, k == 0 || k >= 4);
            chk("s5_busy", k, busy_b, k >= 1 && k <= 6);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
